// File: rtl/video_ntsc_pkg.sv
// Shared widths, levels, sine table and payload types for the composite NTSC encoder.
package video_ntsc_pkg;

  localparam int unsigned RGB_W  = 12;
  localparam int unsigned COMP_W = 4;
  localparam int unsigned Y8_W   = 8;
  localparam int unsigned UV_W   = 9;
  localparam int unsigned ACC_W  = 18;
  localparam int unsigned DAC_W  = 8;
  localparam int unsigned PH_W   = 3;
  localparam int unsigned SIN_W  = 8;

  localparam logic [DAC_W-1:0] DEF_BLANK_LV = 8'd60;
  localparam logic [DAC_W-1:0] DEF_SYNC_LV  = 8'd0;
  localparam logic [DAC_W-1:0] DEF_CLIP_LO  = 8'd16;
  localparam logic [DAC_W-1:0] DEF_CLIP_HI  = 8'd255;

  localparam logic signed [SIN_W-1:0] BURST_GAIN = 8'sd5;
  localparam int unsigned BURST_SHIFT  = 4;
  localparam int unsigned CHROMA_SHIFT = 9;
  localparam int unsigned LUMA_GAIN    = 9;
  localparam int unsigned LUMA_SHIFT   = 4;

  typedef logic signed [SIN_W-1:0] sin_t;

  typedef struct packed {
    logic [COMP_W-1:0] r;
    logic [COMP_W-1:0] g;
    logic [COMP_W-1:0] b;
  } rgb_t;

  typedef struct packed {
    logic xsync;
    logic xblk;
    logic cburst;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{xsync: 1'b1, xblk: 1'b0, cburst: 1'b0};

  // Eight-step subcarrier sine, amplitude 64.
  function automatic sin_t sin_lut(input logic [PH_W-1:0] p);
    sin_t s;
    case (p)
      3'd0:    s = 8'sd0;
      3'd1:    s = 8'sd45;
      3'd2:    s = 8'sd64;
      3'd3:    s = 8'sd45;
      3'd4:    s = 8'sd0;
      3'd5:    s = -8'sd45;
      3'd6:    s = -8'sd64;
      default: s = -8'sd45;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ntsc_chroma_mod.sv
// Second-stage chroma datapath: sine lookups, quadrature products and burst offset.
module ntsc_chroma_mod
  import video_ntsc_pkg::*;
(
  input  logic signed [UV_W-1:0]  u9_i,
  input  logic signed [UV_W-1:0]  v9_i,
  input  logic        [PH_W-1:0]  idx_u_i,
  input  logic        [PH_W-1:0]  idx_v_i,
  input  logic        [PH_W-1:0]  idx_b_i,
  output logic signed [ACC_W-1:0] prod_u_c,
  output logic signed [ACC_W-1:0] prod_v_c,
  output logic signed [SIN_W-1:0] burst_off_c
);

  sin_t                    sin_u;
  sin_t                    sin_v;
  sin_t                    sin_b;
  logic signed [ACC_W-1:0] burst_prod;

  always_comb begin
    sin_u       = sin_lut(idx_u_i);
    sin_v       = sin_lut(idx_v_i);
    sin_b       = sin_lut(idx_b_i);
    prod_u_c    = ACC_W'(u9_i) * ACC_W'(sin_u);
    prod_v_c    = (ACC_W'(v9_i) * ACC_W'(sin_v)) <<< 1;
    burst_prod  = ACC_W'(sin_b) * ACC_W'(BURST_GAIN);
    burst_off_c = SIN_W'(burst_prod >>> BURST_SHIFT);
  end

endmodule

// File: rtl/video_ntsc_enc.sv
// Three-stage composite NTSC encoder: luma, chroma, burst, sync and blank into one DAC code.
// Colour path is built only when VIDEO_NTSC_ENC_CHROMA_EN is defined; otherwise monochrome.
module video_ntsc_enc
  import video_ntsc_pkg::*;
#(
  parameter logic [DAC_W-1:0] C_BLANK_LV = DEF_BLANK_LV,
  parameter logic [DAC_W-1:0] C_SYNC_LV  = DEF_SYNC_LV,
  parameter logic [DAC_W-1:0] C_CLIP_LO  = DEF_CLIP_LO,
  parameter logic [DAC_W-1:0] C_CLIP_HI  = DEF_CLIP_HI
) (
  input  logic              CK_i,
  input  logic              XARST_i,
  input  logic              CK_EE_i,
  input  logic              RST_i,
  input  logic [RGB_W-1:0]  RGBs_i,
  input  logic              XBLK_i,
  input  logic              XSYNC_i,
  input  logic              CBURST_i,
  input  logic [PH_W-1:0]   CPHs_i,
  output logic [DAC_W-1:0]  DAC_o,
  output logic              XSYNC_o,
  output logic              XBLK_o
);

  ctrl_t             ctrl1_q, ctrl1_d;
  ctrl_t             ctrl2_q, ctrl2_d;
  logic [Y8_W-1:0]   y8_q, y8_d;
  logic [DAC_W-1:0]  luma_q, luma_d;
  logic [DAC_W-1:0]  dac_q, dac_d;
  logic              xsync_o_q, xsync_o_d;
  logic              xblk_o_q, xblk_o_d;

  rgb_t                    rgb;
  logic [Y8_W-1:0]         y8_new;
  logic [DAC_W-1:0]        luma_new;
  logic signed [ACC_W-1:0] chroma;
  logic signed [ACC_W-1:0] mix;
  logic [DAC_W-1:0]        burst_lv;
  logic [DAC_W-1:0]        active_lv;

`ifdef VIDEO_NTSC_ENC_CHROMA_EN
  logic signed [UV_W-1:0]  u9_q, u9_d;
  logic signed [UV_W-1:0]  v9_q, v9_d;
  logic [PH_W-1:0]         idx_u_q, idx_u_d;
  logic [PH_W-1:0]         idx_v_q, idx_v_d;
  logic [PH_W-1:0]         idx_b_q, idx_b_d;
  logic signed [ACC_W-1:0] prod_u_q, prod_u_d;
  logic signed [ACC_W-1:0] prod_v_q, prod_v_d;
  logic [DAC_W-1:0]        burst_q, burst_d;
  logic signed [ACC_W-1:0] prod_u_c;
  logic signed [ACC_W-1:0] prod_v_c;
  logic signed [SIN_W-1:0] burst_off_c;

  ntsc_chroma_mod u_chroma (
    .u9_i        (u9_q),
    .v9_i        (v9_q),
    .idx_u_i     (idx_u_q),
    .idx_v_i     (idx_v_q),
    .idx_b_i     (idx_b_q),
    .prod_u_c    (prod_u_c),
    .prod_v_c    (prod_v_c),
    .burst_off_c (burst_off_c)
  );
`else
  logic unused_cphs;
  assign unused_cphs = ^CPHs_i;
`endif

  always_comb begin
    rgb      = rgb_t'(RGBs_i);
    y8_new   = Y8_W'(rgb.r) * 8'd5 + Y8_W'(rgb.g) * 8'd9 + Y8_W'(rgb.b) * 8'd2;
    luma_new = C_BLANK_LV + DAC_W'((12'(y8_q) * 12'(LUMA_GAIN)) >> LUMA_SHIFT);
`ifdef VIDEO_NTSC_ENC_CHROMA_EN
    chroma   = (prod_u_q + prod_v_q) >>> CHROMA_SHIFT;
    burst_lv = burst_q;
`else
    chroma   = '0;
    burst_lv = C_BLANK_LV;
`endif
    mix = ACC_W'($signed({1'b0, luma_q})) + chroma;
    if (mix < $signed(ACC_W'(C_CLIP_LO))) begin
      active_lv = C_CLIP_LO;
    end else if (mix > $signed(ACC_W'(C_CLIP_HI))) begin
      active_lv = C_CLIP_HI;
    end else begin
      active_lv = DAC_W'(mix);
    end

    ctrl1_d   = ctrl1_q;
    ctrl2_d   = ctrl2_q;
    y8_d      = y8_q;
    luma_d    = luma_q;
    dac_d     = dac_q;
    xsync_o_d = xsync_o_q;
    xblk_o_d  = xblk_o_q;
`ifdef VIDEO_NTSC_ENC_CHROMA_EN
    u9_d     = u9_q;
    v9_d     = v9_q;
    idx_u_d  = idx_u_q;
    idx_v_d  = idx_v_q;
    idx_b_d  = idx_b_q;
    prod_u_d = prod_u_q;
    prod_v_d = prod_v_q;
    burst_d  = burst_q;
`endif

    if (CK_EE_i) begin
      if (RST_i) begin
        ctrl1_d   = CTRL_IDLE;
        ctrl2_d   = CTRL_IDLE;
        y8_d      = '0;
        luma_d    = C_BLANK_LV;
        dac_d     = C_BLANK_LV;
        xsync_o_d = 1'b1;
        xblk_o_d  = 1'b0;
`ifdef VIDEO_NTSC_ENC_CHROMA_EN
        u9_d     = '0;
        v9_d     = '0;
        idx_u_d  = '0;
        idx_v_d  = '0;
        idx_b_d  = '0;
        prod_u_d = '0;
        prod_v_d = '0;
        burst_d  = C_BLANK_LV;
`endif
      end else begin
        // S1: capture inputs, luma sum, colour differences, phase indices
        ctrl1_d = '{xsync: XSYNC_i, xblk: XBLK_i, cburst: CBURST_i};
        y8_d    = y8_new;
`ifdef VIDEO_NTSC_ENC_CHROMA_EN
        u9_d    = $signed({1'b0, rgb.b, 4'b0000}) - $signed({1'b0, y8_new});
        v9_d    = $signed({1'b0, rgb.r, 4'b0000}) - $signed({1'b0, y8_new});
        idx_u_d = CPHs_i;
        idx_v_d = CPHs_i + 3'd2;
        idx_b_d = CPHs_i + 3'd4;
`endif
        // S2: luma scale plus chroma products
        ctrl2_d = ctrl1_q;
        luma_d  = luma_new;
`ifdef VIDEO_NTSC_ENC_CHROMA_EN
        prod_u_d = prod_u_c;
        prod_v_d = prod_v_c;
        burst_d  = DAC_W'($signed({2'b00, C_BLANK_LV}) + 10'(burst_off_c));
`endif
        // S3: sync beats burst beats blank beats active video
        if (!ctrl2_q.xsync) begin
          dac_d = C_SYNC_LV;
        end else if (ctrl2_q.cburst) begin
          dac_d = burst_lv;
        end else if (!ctrl2_q.xblk) begin
          dac_d = C_BLANK_LV;
        end else begin
          dac_d = active_lv;
        end
        xsync_o_d = ctrl2_q.xsync;
        xblk_o_d  = ctrl2_q.xblk;
      end
    end
  end

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      ctrl1_q   <= CTRL_IDLE;
      ctrl2_q   <= CTRL_IDLE;
      y8_q      <= '0;
      luma_q    <= C_BLANK_LV;
      dac_q     <= C_BLANK_LV;
      xsync_o_q <= 1'b1;
      xblk_o_q  <= 1'b0;
`ifdef VIDEO_NTSC_ENC_CHROMA_EN
      u9_q     <= '0;
      v9_q     <= '0;
      idx_u_q  <= '0;
      idx_v_q  <= '0;
      idx_b_q  <= '0;
      prod_u_q <= '0;
      prod_v_q <= '0;
      burst_q  <= C_BLANK_LV;
`endif
    end else begin
      ctrl1_q   <= ctrl1_d;
      ctrl2_q   <= ctrl2_d;
      y8_q      <= y8_d;
      luma_q    <= luma_d;
      dac_q     <= dac_d;
      xsync_o_q <= xsync_o_d;
      xblk_o_q  <= xblk_o_d;
`ifdef VIDEO_NTSC_ENC_CHROMA_EN
      u9_q     <= u9_d;
      v9_q     <= v9_d;
      idx_u_q  <= idx_u_d;
      idx_v_q  <= idx_v_d;
      idx_b_q  <= idx_b_d;
      prod_u_q <= prod_u_d;
      prod_v_q <= prod_v_d;
      burst_q  <= burst_d;
`endif
    end
  end

  assign DAC_o   = dac_q;
  assign XSYNC_o = xsync_o_q;
  assign XBLK_o  = xblk_o_q;

endmodule
